// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arb_pkg
//  Purpose  : Shared FSM state type, port indices and widths for the
//             SDRAM port arbiter.
//  Revision : 1.0
// ============================================================================
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam logic [1:0] RD0 = 2'd0;
    localparam logic [1:0] RD1 = 2'd1;
    localparam logic [1:0] WR0 = 2'd2;
    localparam logic [1:0] WR1 = 2'd3;

    localparam int unsigned RST_LENGTH = 128;
    localparam int unsigned NUM_PORTS  = 4;
    localparam int unsigned LEN_W      = 9;
    localparam int unsigned USEDW_W    = 16;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic is_read_port(input logic [1:0] idx);
        return (idx == RD0) || (idx == RD1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_port_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_port_addr_gen
//  Purpose  : Per-port burst pointer and length with load and wrap handling.
//  Revision : 1.0
// ============================================================================
module sdram_port_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter int ASIZE     = 22,
    parameter int RESET_LEN = RST_LENGTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [ASIZE-1:0] start_addr,
    input  logic [ASIZE-1:0] max_addr,
    input  logic [LEN_W-1:0] length,
    output logic [ASIZE-1:0] ptr,
    output logic [LEN_W-1:0] len
);

    logic [ASIZE-1:0] r_ptr;
    logic [LEN_W-1:0] r_len;
    logic [ASIZE:0]   w_limit;
    logic             w_wrap;

    // One extra bit keeps MAX_ADDR < len visible as a borrow, which forces a wrap.
    always_comb begin
        w_limit = {1'b0, max_addr} - (ASIZE+1)'(r_len);
        w_wrap  = w_limit[ASIZE] || ({1'b0, r_ptr} >= w_limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_len <= LEN_W'(RESET_LEN);
        end else if (load) begin
            r_ptr <= start_addr;
            r_len <= length;
        end else if (advance) begin
            if (w_wrap) begin
                r_ptr <= start_addr;
            end else begin
                r_ptr <= r_ptr + ASIZE'(r_len);
            end
        end
    end

    assign ptr = r_ptr;
    assign len = r_len;

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_port_arbiter
//  Purpose  : Arbitrates two read and two write FIFO ports onto one SDRAM
//             burst engine. Optional macro SDRAM_ARB_RR_EN enables
//             round-robin within each class (default: fixed priority).
//  Revision : 1.0
// ============================================================================
module sdram_port_arbiter #(
    parameter int ASIZE      = 22,
    parameter int RST_LENGTH = 128
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [3:0]         LOAD,
    input  logic [4*ASIZE-1:0] START_ADDR,
    input  logic [4*ASIZE-1:0] MAX_ADDR,
    input  logic [4*9-1:0]     LENGTH,
    input  logic [4*16-1:0]    USEDW,
    input  logic               BURST_DONE,
    input  logic               ENGINE_IDLE,
    output logic               REQ_RD,
    output logic               REQ_WR,
    output logic [ASIZE-1:0]   REQ_ADDR,
    output logic [8:0]         REQ_LENGTH,
    output logic [3:0]         GRANT
);
    import sdram_arb_pkg::*;

    state_t                          r_state;
    logic [1:0]                      r_sel;
    logic [NUM_PORTS-1:0][ASIZE-1:0] w_ptr;
    logic [NUM_PORTS-1:0][LEN_W-1:0] w_len;
    logic [NUM_PORTS-1:0]            w_elig;
    logic [NUM_PORTS-1:0]            w_advance;
    logic                            w_any;
    logic [1:0]                      w_pick;

`ifdef SDRAM_ARB_RR_EN
    logic r_rr_rd;
    logic r_rr_wr;
`endif

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [USEDW_W-1:0] w_fill;
            assign w_fill        = USEDW[gi*USEDW_W +: USEDW_W];
            assign w_advance[gi] = (r_state == ST_UPDATE) && (r_sel == 2'(gi));

            if (gi < 2) begin : g_rd
                assign w_elig[gi] = w_fill < USEDW_W'(w_len[gi]);
            end else begin : g_wr
                assign w_elig[gi] = (w_fill >= USEDW_W'(w_len[gi])) && (w_len[gi] != '0);
            end

            sdram_port_addr_gen #(
                .ASIZE     (ASIZE),
                .RESET_LEN (RST_LENGTH)
            ) u_addr_gen (
                .clk        (CLK),
                .rst_n      (RESET_N),
                .load       (LOAD[gi]),
                .advance    (w_advance[gi]),
                .start_addr (START_ADDR[gi*ASIZE +: ASIZE]),
                .max_addr   (MAX_ADDR[gi*ASIZE +: ASIZE]),
                .length     (LENGTH[gi*LEN_W +: LEN_W]),
                .ptr        (w_ptr[gi]),
                .len        (w_len[gi])
            );
        end
    endgenerate

    // Reads always beat writes; the macro only changes the order inside a class.
    always_comb begin
        w_any  = |w_elig;
        w_pick = RD0;
`ifdef SDRAM_ARB_RR_EN
        if (w_elig[RD0] && w_elig[RD1]) begin
            w_pick = r_rr_rd ? RD1 : RD0;
        end else if (w_elig[RD0]) begin
            w_pick = RD0;
        end else if (w_elig[RD1]) begin
            w_pick = RD1;
        end else if (w_elig[WR0] && w_elig[WR1]) begin
            w_pick = r_rr_wr ? WR1 : WR0;
        end else if (w_elig[WR0]) begin
            w_pick = WR0;
        end else if (w_elig[WR1]) begin
            w_pick = WR1;
        end
`else
        if (w_elig[RD0]) begin
            w_pick = RD0;
        end else if (w_elig[RD1]) begin
            w_pick = RD1;
        end else if (w_elig[WR0]) begin
            w_pick = WR0;
        end else if (w_elig[WR1]) begin
            w_pick = WR1;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_sel      <= RD0;
            REQ_RD     <= 1'b0;
            REQ_WR     <= 1'b0;
            REQ_ADDR   <= '0;
            REQ_LENGTH <= '0;
            GRANT      <= '0;
`ifdef SDRAM_ARB_RR_EN
            r_rr_rd    <= 1'b0;
            r_rr_wr    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ENGINE_IDLE && (LOAD == 4'b0000) && w_any) begin
                        r_sel      <= w_pick;
                        GRANT      <= port_onehot(w_pick);
                        REQ_ADDR   <= w_ptr[w_pick];
                        REQ_LENGTH <= w_len[w_pick];
`ifdef SDRAM_ARB_RR_EN
                        case (w_pick)
                            RD0:     r_rr_rd <= 1'b1;
                            RD1:     r_rr_rd <= 1'b0;
                            WR0:     r_rr_wr <= 1'b1;
                            default: r_rr_wr <= 1'b0;
                        endcase
`endif
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    REQ_RD  <= is_read_port(r_sel);
                    REQ_WR  <= !is_read_port(r_sel);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (BURST_DONE) begin
                        REQ_RD  <= 1'b0;
                        REQ_WR  <= 1'b0;
                        GRANT   <= '0;
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_port_arbiter
//  Purpose  : Scoreboard bench for sdram_port_arbiter with a scripted engine.
//  Revision : 1.0
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int AW = 22;

    logic            CLK;
    logic            RESET_N;
    logic [3:0]      LOAD;
    logic [4*AW-1:0] START_ADDR;
    logic [4*AW-1:0] MAX_ADDR;
    logic [35:0]     LENGTH;
    logic [63:0]     USEDW;
    logic            BURST_DONE;
    logic            ENGINE_IDLE;
    logic            REQ_RD;
    logic            REQ_WR;
    logic [AW-1:0]   REQ_ADDR;
    logic [8:0]      REQ_LENGTH;
    logic [3:0]      GRANT;

    typedef struct packed {
        logic [3:0]    grant;
        logic [AW-1:0] addr;
        logic [8:0]    len;
        logic          rd;
        logic          wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   grant_count = 0;

    sdram_port_arbiter #(.ASIZE(AW), .RST_LENGTH(128)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .LOAD        (LOAD),
        .START_ADDR  (START_ADDR),
        .MAX_ADDR    (MAX_ADDR),
        .LENGTH      (LENGTH),
        .USEDW       (USEDW),
        .BURST_DONE  (BURST_DONE),
        .ENGINE_IDLE (ENGINE_IDLE),
        .REQ_RD      (REQ_RD),
        .REQ_WR      (REQ_WR),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_LENGTH  (REQ_LENGTH),
        .GRANT       (GRANT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    // Monitor: pops one expectation per rising request, then checks it stays stable.
    initial begin
        logic prev;
        exp_t cur;
        exp_t e;
        exp_t held;
        prev = 1'b0;
        held = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (REQ_RD || REQ_WR) begin
                cur.grant = GRANT;
                cur.addr  = REQ_ADDR;
                cur.len   = REQ_LENGTH;
                cur.rd    = REQ_RD;
                cur.wr    = REQ_WR;
                if (!prev) begin
                    grant_count++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_grant: got grant=%b addr=%0d len=%0d, required no grant",
                                 cur.grant, cur.addr, cur.len);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL grant_%0d: got grant=%b addr=%0d len=%0d rd=%b wr=%b, required grant=%b addr=%0d len=%0d rd=%b wr=%b",
                                     grant_count, cur.grant, cur.addr, cur.len, cur.rd, cur.wr,
                                     e.grant, e.addr, e.len, e.rd, e.wr);
                        end
                    end
                    held = cur;
                end else begin
                    checks++;
                    if (cur !== held) begin
                        errors++;
                        $display("FAIL hold_%0d: got grant=%b addr=%0d len=%0d, required grant=%b addr=%0d len=%0d",
                                 grant_count, cur.grant, cur.addr, cur.len, held.grant, held.addr, held.len);
                    end
                end
            end
            prev = REQ_RD || REQ_WR;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] g, input int addr, input int len);
        exp_t e;
        e.grant = g;
        e.addr  = AW'(addr);
        e.len   = 9'(len);
        e.rd    = |g[1:0];
        e.wr    = |g[3:2];
        exp_q.push_back(e);
    endtask

    task automatic set_usedw(input int p, input int v);
        USEDW[p*16 +: 16] = 16'(v);
    endtask

    task automatic make_idle(input int p);
        set_usedw(p, (p < 2) ? 16'hFFFF : 0);
    endtask

    task automatic wait_req(output int lat);
        lat = 0;
        while (!(REQ_RD || REQ_WR) && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        if (!(REQ_RD || REQ_WR)) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no request after %0d cycles, required a request", lat);
        end
    endtask

    // Scripted burst engine: accept, clear chosen FIFOs mid-grant, finish, optional LOAD on UPDATE.
    task automatic burst(input logic [3:0] clr, input logic [3:0] ld, input int hold, output int lat);
        wait_req(lat);
        ENGINE_IDLE = 1'b0;
        for (int p = 0; p < 4; p++) if (clr[p]) make_idle(p);
        repeat (3) @(negedge CLK);
        BURST_DONE = 1'b1;
        @(negedge CLK);
        BURST_DONE  = 1'b0;
        ENGINE_IDLE = 1'b1;
        if (ld != 4'b0000) begin
            LOAD = ld;
            repeat (hold) @(negedge CLK);
            LOAD = 4'b0000;
        end
    endtask

    initial begin
        int lat;
        int g0;
        RESET_N     = 1'b0;
        LOAD        = 4'b0000;
        BURST_DONE  = 1'b0;
        ENGINE_IDLE = 1'b1;
        START_ADDR  = '0;
        MAX_ADDR    = {4{22'd384000}};
        LENGTH      = {4{9'd128}};
        USEDW       = '0;
        for (int p = 0; p < 4; p++) make_idle(p);
        repeat (3) @(negedge CLK);
        chk("rst_req_rd", REQ_RD, 0);
        chk("rst_req_wr", REQ_WR, 0);
        chk("rst_grant", GRANT, 0);
        chk("rst_req_addr", REQ_ADDR, 0);
        chk("rst_req_length", REQ_LENGTH, 0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // First read grant and its latency; the second grant proves ptr0 advanced to 128
        push(4'b0001, 0, 128);
        set_usedw(0, 0);
        burst(4'b0001, 4'b0000, 0, lat);
        chk("first_latency", lat, 2);
        push(4'b0001, 128, 128);
        set_usedw(0, 0);
        burst(4'b0001, 4'b0000, 0, lat);

        // Read beats write; write follows on the next decision
        push(4'b0001, 256, 128);
        push(4'b0100, 0, 128);
        set_usedw(0, 0);
        set_usedw(2, 200);
        burst(4'b0001, 4'b0000, 0, lat);
        burst(4'b0100, 4'b0000, 0, lat);

        // Wrap at MAX_ADDR=384000 for port 1
        START_ADDR[1*AW +: AW] = 22'd383744;
        LOAD = 4'b0010;
        @(negedge CLK);
        LOAD = 4'b0000;
        START_ADDR[1*AW +: AW] = '0;
        push(4'b0010, 383744, 128);
        push(4'b0010, 383872, 128);
        push(4'b0010, 0, 128);
        set_usedw(1, 0);
        burst(4'b0000, 4'b0000, 0, lat);
        burst(4'b0000, 4'b0000, 0, lat);
        burst(4'b0010, 4'b0000, 0, lat);

        // MAX_ADDR below len forces a wrap; USEDW equal to len is eligible
        START_ADDR[3*AW +: AW] = 22'd50;
        MAX_ADDR[3*AW +: AW]   = 22'd100;
        LENGTH[3*9 +: 9]       = 9'd200;
        LOAD = 4'b1000;
        @(negedge CLK);
        LOAD = 4'b0000;
        push(4'b1000, 50, 200);
        push(4'b1000, 50, 200);
        set_usedw(3, 200);
        burst(4'b0000, 4'b0000, 0, lat);
        burst(4'b1000, 4'b0000, 0, lat);

        // LOAD on port 2's UPDATE wins; no grant while LOAD is held
        START_ADDR[2*AW +: AW] = 22'd1000;
        push(4'b0100, 128, 128);
        set_usedw(2, 200);
        burst(4'b0000, 4'b0100, 4, lat);
        push(4'b0100, 1000, 128);
        burst(4'b0100, 4'b0000, 0, lat);

        // Both read ports eligible back to back
`ifdef SDRAM_ARB_RR_EN
        push(4'b0001, 384, 128);
        push(4'b0010, 128, 128);
`else
        push(4'b0001, 384, 128);
        push(4'b0001, 512, 128);
`endif
        set_usedw(0, 0);
        set_usedw(1, 0);
        burst(4'b0000, 4'b0000, 0, lat);
        burst(4'b0011, 4'b0000, 0, lat);

        // Reset in the middle of WAIT clears outputs asynchronously
`ifdef SDRAM_ARB_RR_EN
        push(4'b0001, 512, 128);
`else
        push(4'b0001, 640, 128);
`endif
        set_usedw(0, 0);
        wait_req(lat);
        ENGINE_IDLE = 1'b0;
        make_idle(0);
        repeat (2) @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("midrst_req_rd", REQ_RD, 0);
        chk("midrst_req_wr", REQ_WR, 0);
        chk("midrst_grant", GRANT, 0);
        chk("midrst_req_addr", REQ_ADDR, 0);
        @(negedge CLK);
        RESET_N     = 1'b1;
        ENGINE_IDLE = 1'b1;

        // Eligibility boundaries one below/at len; stray BURST_DONE in IDLE ignored
        set_usedw(2, 127);
        set_usedw(1, 128);
        g0 = grant_count;
        @(negedge CLK);
        BURST_DONE = 1'b1;
        @(negedge CLK);
        BURST_DONE = 1'b0;
        repeat (20) @(negedge CLK);
        chk("no_grant_boundary", grant_count, g0);
        push(4'b0100, 0, 128);
        set_usedw(2, 128);
        burst(4'b0100, 4'b0000, 0, lat);
        push(4'b0001, 0, 128);
        set_usedw(0, 127);
        burst(4'b0001, 4'b0000, 0, lat);

        repeat (5) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
